pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage core.
- Tracks destination registers in flight through EX, MEM and WB in a shadow scoreboard, and detects RAW hazards for the instruction in ID.
- Drives the stall, flush and stage-valid controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences taken-branch redirects and the ebreak drain-then-halt.
- No forwarding exists, so every hazard resolves by stalling.

---
 rtl/pipe_hazard_ctrl_if.sv | 54 +++++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus: ID-stage hazard inputs, branch redirect,
// and the front-end stall/flush and stage-valid controls.
// The PIPE_HAZARD_CTRL_PERF_EN macro adds the stall/flush performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned RA_W = 5
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , parameter int unsigned CNT_W = 32
`endif
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [RA_W-1:0] id_rd;
    logic            id_rd_we;
    logic            id_ebreak;
    logic            ex_redirect;
    logic            pc_stall;
    logic            if_id_stall;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            ex_valid;
    logic            mem_valid;
    logic            wb_valid;
    logic            halted;
    logic [1:0]      state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    // Core side: presents the ID instruction and redirect, consumes controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_ebreak, ex_redirect,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               ex_valid, mem_valid, wb_valid, halted, state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_ebreak, ex_redirect,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               ex_valid, mem_valid, wb_valid, halted, state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage core: shadow scoreboard of in-flight
// destination registers (EX/MEM/WB), RAW stall generation (no forwarding),
// branch-redirect flushes and the ebreak drain-then-halt FSM.
// Optional performance counters are enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned RA_W = 5
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input logic               sys_clk,
    input logic               sys_rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Slot 0 = EX, 1 = MEM, 2 = WB
    localparam int unsigned NSLOT = 3;

    state_t          r_state;
    logic            r_halted;
    logic [NSLOT-1:0] r_v;
    logic [NSLOT-1:0] r_we;
    logic [RA_W-1:0] r_rd [NSLOT];

    logic w_hit1;
    logic w_hit2;
    logic w_hazard;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;

    // RAW detection: any in-flight writer of a used, non-zero source stalls ID
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (r_v[i] && r_we[i] && (r_rd[i] == bus.id_rs1)) w_hit1 = 1'b1;
            if (r_v[i] && r_we[i] && (r_rd[i] == bus.id_rs2)) w_hit2 = 1'b1;
        end
        w_hazard = bus.id_valid &&
                   ((bus.id_rs1_used && (bus.id_rs1 != '0) && w_hit1) ||
                    (bus.id_rs2_used && (bus.id_rs2 != '0) && w_hit2));
    end

    // Front-end controls: redirect beats hazard; DRAIN/HALT freeze and bubble
    always_comb begin
        w_pc_stall    = 1'b0;
        w_if_id_stall = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        if (r_state == ST_RUN) begin
            if (bus.ex_redirect) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_hazard) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end
        end else begin
            w_pc_stall    = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end
    end

    // Scoreboard shifts every cycle; a flushed ID instruction enters as a bubble
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_v  <= '0;
            r_we <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) r_rd[i] <= '0;
        end else begin
            r_v  <= {r_v[NSLOT-2:0], bus.id_valid & ~w_id_ex_flush};
            r_we <= {r_we[NSLOT-2:0], bus.id_rd_we};
            r_rd[0] <= bus.id_rd;
            for (int unsigned i = 1; i < NSLOT; i++) r_rd[i] <= r_rd[i-1];
        end
    end

    // ebreak FSM; HALT is entered on the edge after which EX/MEM/WB are all empty
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!bus.ex_redirect && !w_hazard && bus.id_valid && bus.id_ebreak)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // ID is always bubbled here, so only EX and MEM can refill MEM/WB
                    if (!r_v[0] && !r_v[1]) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Count accepted redirects and hazard stalls in RUN; wrap naturally
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (bus.ex_redirect)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            else if (w_hazard)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

    assign bus.pc_stall    = w_pc_stall;
    assign bus.if_id_stall = w_if_id_stall;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.ex_valid    = r_v[0];
    assign bus.mem_valid   = r_v[1];
    assign bus.wb_valid    = r_v[2];
    assign bus.halted      = r_halted;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, every cycle compared against a queue-based pipeline model.
// Counter checks are included when PIPE_HAZARD_CTRL_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RA_W(5)) bus ();
    pipe_hazard_ctrl #(.RA_W(5)) dut (.sys_clk(clk), .sys_rst(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
    } slot_t;

    // Model: in-flight instructions, newest first (EX, MEM, WB)
    slot_t       inflight[$];
    int          m_mode;      // 0 running, 1 draining, 2 halted
    bit          m_known;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;
    logic        e_pc, e_ifs, e_iff, e_ief, e_hz;

    // Samples taken at the last negedge
    logic       s_pc, s_ifs, s_iff, s_ief, s_ex, s_mem, s_wb, s_halted;
    logic [1:0] s_state;
    logic [31:0] s_stall_cnt, s_flush_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending_write(input logic [4:0] r);
        foreach (inflight[k])
            if (inflight[k].v && inflight[k].we && inflight[k].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_expect();
        e_hz = bus.id_valid &&
               ((bus.id_rs1_used && bus.id_rs1 != 5'd0 && pending_write(bus.id_rs1)) ||
                (bus.id_rs2_used && bus.id_rs2 != 5'd0 && pending_write(bus.id_rs2)));
        {e_pc, e_ifs, e_iff, e_ief} = 4'b0000;
        if (m_mode != 0)          {e_pc, e_ifs, e_iff, e_ief} = 4'b1011;
        else if (bus.ex_redirect) {e_pc, e_ifs, e_iff, e_ief} = 4'b0011;
        else if (e_hz)            {e_pc, e_ifs, e_iff, e_ief} = 4'b1101;
    endtask

    task automatic model_update();
        slot_t s;
        bit    any_v;
        if (!rst_n) begin
            inflight = {};
            repeat (3) inflight.push_back('0);
            m_mode      = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
            m_known     = 1'b1;
            return;
        end
        if (m_mode == 0 && bus.ex_redirect) m_flush_cnt++;
        else if (m_mode == 0 && e_hz)       m_stall_cnt++;
        s.v  = bus.id_valid && !e_ief;
        s.rd = bus.id_rd;
        s.we = bus.id_rd_we;
        inflight.push_front(s);
        void'(inflight.pop_back());
        any_v = 1'b0;
        foreach (inflight[k]) any_v |= inflight[k].v;
        if (m_mode == 0 && !bus.ex_redirect && !e_hz && bus.id_valid && bus.id_ebreak)
            m_mode = 1;
        else if (m_mode == 1 && !any_v)
            m_mode = 2;
    endtask

    // One clock: check at negedge, advance model at posedge, return 1 after it
    task automatic cycle();
        @(negedge clk);
        model_expect();
        s_pc = bus.pc_stall;   s_ifs = bus.if_id_stall;
        s_iff = bus.if_id_flush; s_ief = bus.id_ex_flush;
        s_ex = bus.ex_valid;   s_mem = bus.mem_valid; s_wb = bus.wb_valid;
        s_halted = bus.halted; s_state = bus.state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        s_stall_cnt = bus.stall_cnt;
        s_flush_cnt = bus.flush_cnt;
`else
        s_stall_cnt = '0;
        s_flush_cnt = '0;
`endif
        if (m_known) begin
            chk("pc_stall", s_pc, e_pc);
            chk("if_id_stall", s_ifs, e_ifs);
            chk("if_id_flush", s_iff, e_iff);
            chk("id_ex_flush", s_ief, e_ief);
            chk("ex_valid", s_ex, inflight[0].v);
            chk("mem_valid", s_mem, inflight[1].v);
            chk("wb_valid", s_wb, inflight[2].v);
            chk("halted", s_halted, m_mode == 2);
            chk("state", s_state, m_mode);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            chk("stall_cnt", s_stall_cnt, m_stall_cnt);
            chk("flush_cnt", s_flush_cnt, m_flush_cnt);
`endif
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic eb, input logic redir);
        bus.id_valid = v;   bus.id_rs1 = rs1; bus.id_rs1_used = u1;
        bus.id_rs2 = rs2;   bus.id_rs2_used = u2;
        bus.id_rd = rd;     bus.id_rd_we = we;
        bus.id_ebreak = eb; bus.ex_redirect = redir;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic stl[4];
        logic exv[5];
        logic [1:0] st[4];
        logic hl[4];
        logic exp_ex[5];
        logic [1:0] exp_st[4];
        exp_ex = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_st = '{2'd1, 2'd1, 2'd1, 2'd2};
        m_known = 1'b0;
        inflight = {};
        repeat (3) inflight.push_back('0);
        m_mode = 0; m_stall_cnt = 0; m_flush_cnt = 0;

        // Reset
        rst_n = 1'b0;
        idle();
        cycle();
        cycle();
        chk("rst_state", s_state, 2'd0);
        chk("rst_halted", s_halted, 1'b0);
        chk("rst_ex_valid", s_ex, 1'b0);
        chk("rst_pc_stall", s_pc, 1'b0);
        rst_n = 1'b1;

        // Producer rd=5, then consumer of rs1=5: three stall cycles
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            stl[k] = s_pc & s_ifs & s_ief;
            exv[k] = s_ex;
        end
        idle();
        cycle();
        exv[4] = s_ex;
        for (int k = 0; k < 4; k++) chk("raw_stall_seq", stl[k], k < 3);
        for (int k = 0; k < 5; k++) chk("raw_ex_valid_seq", exv[k], exp_ex[k]);

        // x0 is never a hazard; a non-writing producer is never a hazard
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("x0_no_stall", s_pc, 1'b0);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("nowe_no_stall", s_pc, 1'b0);

        // Redirect while ID holds a hazarded instruction
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("redir_if_id_flush", s_iff, 1'b1);
        chk("redir_id_ex_flush", s_ief, 1'b1);
        chk("redir_pc_stall", s_pc, 1'b0);
        idle();
        cycle();
        chk("redir_ex_bubble", s_ex, 1'b0);

        // ebreak drain then halt; redirect/hazard inputs are ignored while draining
        idle();
        repeat (3) cycle();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            st[k] = s_state;
            hl[k] = s_halted;
            chk("drain_pc_stall", s_pc, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            chk("drain_state_seq", st[k], exp_st[k]);
            chk("drain_halted_seq", hl[k], k == 3);
        end
        idle();
        repeat (2) cycle();
        chk("halt_held", s_halted, 1'b1);

        // Reset out of HALT
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("halt_rst_state", s_state, 2'd0);
        chk("halt_rst_halted", s_halted, 1'b0);

        // Reset in the second DRAIN cycle
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle();
        idle();
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("drain2_state", s_state, 2'd1);
        rst_n = 1'b1;
        cycle();
        chk("drain_rst_state", s_state, 2'd0);
        chk("drain_rst_halted", s_halted, 1'b0);
        chk("drain_rst_valids", {s_ex, s_mem, s_wb}, 3'b000);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        // One 3-cycle stall plus two redirects
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle();
        idle();
        cycle();
        chk("perf_stall_cnt", s_stall_cnt, 32'd3);
        chk("perf_flush_cnt", s_flush_cnt, 32'd2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("perf_rst_stall_cnt", s_stall_cnt, 32'd0);
        chk("perf_rst_flush_cnt", s_flush_cnt, 32'd0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 9) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 6) == 0));
            rst_n = !((m_mode == 2 && $urandom_range(0, 3) == 0) ||
                      $urandom_range(0, 99) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
